// File: rtl/seg7_scan_display_pkg.sv
// Shared types and segment patterns for the 4-digit multiplexed clock display.
package seg7_pkg;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] bcd_t;

    localparam int NUM_DIGITS = 4;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/seg7_scan_display_if.sv
// Time-digit inputs and display drive lines between the time counter and the scanner.
interface seg7_scan_display_if;
    import seg7_pkg::*;

    bcd_t       min;
    bcd_t       min2;
    bcd_t       hr1;
    bcd_t       hr2;
    logic       sec_tick;
    logic       blink_en;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    // Time source side: supplies digits and tick, observes the display lines
    modport master (
        output min, min2, hr1, hr2, sec_tick, blink_en,
        input  seg, dp, an
    );

    // Scanner side
    modport slave (
        input  min, min2, hr1, hr2, sec_tick, blink_en,
        output seg, dp, an
    );

endinterface

// File: rtl/seg7_scan_display_bcd_to_seg7.sv
// Stateless BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    // Lookup of the segment pattern for one digit
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 4-digit common-anode display scanner with per-frame digit
// capture, hour-tens zero blanking, blinking colon and inter-digit dead time.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SLOT_HZ   = 4_000,
    parameter int BLANK_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_display_if.slave   bus
);

    localparam int DIV   = CLK_HZ / SLOT_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] BLANK_V  = PRE_W'(BLANK_CYC);

    if (DIV < 2) begin : g_div_chk
        $error("seg7_scan_display: CLK_HZ/SLOT_HZ must be at least 2");
    end
    if (BLANK_CYC >= DIV) begin : g_blank_chk
        $error("seg7_scan_display: BLANK_CYC must be smaller than the slot length");
    end

    logic [PRE_W-1:0] pre_q, pre_d;
    digit_idx_t       idx_q, idx_d;
    bcd_t [3:0]       snap_q, snap_d;
    logic             colon_q, colon_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             slot_end;
    logic             frame_end;
    bcd_t             cur_digit;
    logic [6:0]       cur_seg;

    assign slot_end  = (pre_q == PRE_LAST);
    assign frame_end = slot_end && (idx_q == 2'd3);
    assign cur_digit = snap_q[idx_q];

    bcd_to_seg7 u_dec (
        .bcd_i (cur_digit),
        .seg_o (cur_seg)
    );

    // Scan timing, frame capture and colon state; a tick and a slot
    // boundary in the same cycle update independent registers
    always_comb begin
        pre_d   = slot_end ? '0 : pre_q + 1'b1;
        idx_d   = slot_end ? idx_q + 2'd1 : idx_q;
        snap_d  = frame_end ? {bus.hr2, bus.hr1, bus.min2, bus.min} : snap_q;
        colon_d = colon_q;
        if (!bus.blink_en) begin
            colon_d = 1'b1;
        end else if (bus.sec_tick) begin
            colon_d = ~colon_q;
        end
    end

    // Next display drive: dark during the dead time, otherwise one digit lit
    always_comb begin
        an_d  = 4'hF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (pre_q >= BLANK_V) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = cur_seg;
            dp_d  = (idx_q == 2'd2) ? ~colon_q : 1'b1;
            // Hour tens of zero is suppressed rather than shown as a leading 0
            if ((idx_q == 2'd3) && (snap_q[3] == 4'd0)) begin
                an_d = 4'hF;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            colon_q <= 1'b1;
            an_q    <= 4'hF;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            colon_q <= colon_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: directed scenarios plus random traffic, checked
// every cycle against a frame/slot arithmetic model of the display.
module tb_seg7_scan_display;

    localparam int CLK_HZ    = 1000;
    localparam int SLOT_HZ   = 250;
    localparam int BLANK_CYC = 1;
    localparam int DIV       = CLK_HZ / SLOT_HZ;
    localparam int FRAME     = 4 * DIV;

    logic clk = 1'b0;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: cycles since reset, digits shown this frame, colon
    int       p = 0;
    bit [3:0] snap_m [4];
    bit       colon_m = 1'b1;

    seg7_scan_display_if dif ();

    seg7_scan_display #(
        .CLK_HZ    (CLK_HZ),
        .SLOT_HZ   (SLOT_HZ),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input bit [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic int cur_idx();
        return (p / DIV) % 4;
    endfunction

    // One clock: predict from the model, advance the model, then compare
    task automatic cycle();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int         pre;
        int         idx;
        pre   = p % DIV;
        idx   = (p / DIV) % 4;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (!rst && pre >= BLANK_CYC) begin
            e_an[idx] = 1'b0;
            if (idx == 3 && snap_m[3] == 4'd0) e_an = 4'hF;
            e_seg = ref_seg(snap_m[idx]);
            e_dp  = (idx == 2) ? ~colon_m : 1'b1;
        end
        if (rst) begin
            p       = 0;
            snap_m  = '{4'd0, 4'd0, 4'd0, 4'd0};
            colon_m = 1'b1;
        end else begin
            if (pre == DIV - 1 && idx == 3) begin
                snap_m[0] = dif.min;
                snap_m[1] = dif.min2;
                snap_m[2] = dif.hr1;
                snap_m[3] = dif.hr2;
            end
            if (!dif.blink_en) colon_m = 1'b1;
            else if (dif.sec_tick) colon_m = ~colon_m;
            p++;
        end
        @(posedge clk);
        #1;
        chk("an", 32'(dif.an), 32'(e_an));
        chk("seg", 32'(dif.seg), 32'(e_seg));
        chk("dp", 32'(dif.dp), 32'(e_dp));
        chk("an_onehot0", 32'($onehot0(~dif.an)), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_time(input bit [3:0] h2, input bit [3:0] h1,
                            input bit [3:0] m2, input bit [3:0] m1);
        dif.hr2  = h2;
        dif.hr1  = h1;
        dif.min2 = m2;
        dif.min  = m1;
    endtask

    // Advance until the model sits in slot idx; a missed target is a failure
    task automatic wait_idx(input int target);
        int guard;
        guard = 0;
        while (cur_idx() != target && guard < FRAME) begin
            cycle();
            guard++;
        end
        chk("wait_idx_reached", 32'(cur_idx()), 32'(target));
    endtask

    initial begin
        snap_m = '{4'd0, 4'd0, 4'd0, 4'd0};
        rst          = 1'b1;
        dif.sec_tick = 1'b0;
        dif.blink_en = 1'b0;
        set_time(4'd1, 4'd2, 4'd3, 4'd4);

        // Reset then scan 12:34
        run(3);
        rst = 1'b0;
        run(3 * FRAME);

        // Leading zero on the hours
        set_time(4'd0, 4'd9, 4'd3, 4'd4);
        run(3 * FRAME);

        // Invalid BCD in minute units
        set_time(4'd1, 4'd2, 4'd3, 4'hB);
        run(2 * FRAME);

        // Mid-frame input change must wait for the frame boundary
        set_time(4'd1, 4'd2, 4'd3, 4'd4);
        run(2 * FRAME);
        wait_idx(2);
        dif.min = 4'd5;
        run(2 * FRAME);

        // Colon blink, then steady
        dif.blink_en = 1'b1;
        for (int k = 0; k < 240; k++) begin
            dif.sec_tick = (k % 40 == 39);
            cycle();
        end
        dif.sec_tick = 1'b0;
        dif.blink_en = 1'b0;
        for (int k = 0; k < 120; k++) begin
            dif.sec_tick = (k % 40 == 39);
            cycle();
        end
        dif.sec_tick = 1'b0;

        // Reset in the middle of the hour-tens slot
        wait_idx(3);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        run(2 * FRAME);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) dif.min  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) dif.min2 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) dif.hr1  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) dif.hr2  = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) dif.blink_en = ~dif.blink_en;
            dif.sec_tick = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst          = 1'b0;
        dif.sec_tick = 1'b0;
        run(FRAME);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
